sample_sequencer: RTL and testbench
===================================

# sample_sequencer

Upstream feeder for `data_organize`. Accepts a valid/ready stream of 11-bit samples and waits, once armed, for a rising threshold crossing. It then emits 64 decimated samples as a registered (`data`, `dataChange`) pair that sweeps slot index 0..63. It pulses `frame_done` when the frame is complete. `data_organize` writes `data` into slot `dataChange` on every clock, so this block always keeps the pair mutually consistent.

## Interface
- `DATA_W`, 11, sample width
- `ADDR_W`, 6, slot index width
- `DEPTH`, 64, samples per frame (= 2^ADDR_W)
- `DECIM_W`, 8, decimation control width

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream sample valid
- `in_data`  in  DATA_W  upstream sample
- `in_ready`  out  1  block can accept a sample
- `arm`  in  1  single-cycle request to start a frame
- `threshold`  in  DATA_W  trigger level, unsigned
- `decim`  in  DECIM_W  keep 1 of every decim+1 accepted samples
- `data`  out  DATA_W  sample for the current slot
- `dataChange`  out  ADDR_W  current slot index
- `busy`  out  1  high in ARMED and CAPTURE
- `frame_done`  out  1  one-cycle pulse at the end of a frame

## Operation
- **Handshake.** A sample is accepted when `in_valid & in_ready`.
  - `in_ready` = 1 in IDLE, ARMED and CAPTURE; 0 in DONE.
  - In IDLE, accepted samples are discarded.
- **States:** IDLE, ARMED, CAPTURE, DONE.
- **IDLE.**
  - `arm` = 1 → ARMED.
  - Clears `prev_vld`.
- **ARMED.**
  - On every accepted sample, store it in `prev` and set `prev_vld`.
  - Trigger condition: `prev_vld & (prev < threshold) & (in_data >= threshold)`. All comparisons are unsigned, and `threshold` is compared live.
  - The first sample after arming cannot trigger.
  - On trigger:
    - `data` ← `in_data`, `dataChange` ← 0.
    - Latch `decim` into `decim_q`.
    - Clear the decimation counter.
    - → CAPTURE.
- **CAPTURE.**
  - Each accepted sample increments the decimation counter.
  - When the counter equals `decim_q`:
    - The sample is kept: `data` ← `in_data`, `dataChange` ← `dataChange + 1`.
    - The counter clears.
  - With `decim_q = 0`, every accepted sample is kept.
  - Keeping the sample that lands in slot DEPTH-1 → DONE.
- **DONE.** Lasts exactly one cycle, with `frame_done` = 1. Then → IDLE.
- `arm` is ignored in every state except IDLE.
- Changes to `decim` during a frame have no effect.
- Between frames, `data` and `dataChange` hold their last values. The downstream block re-writes the same value into the same slot, which is harmless.
- The index never wraps within a frame; each frame starts again at 0.

## Timing
- **Reset values:**
  - state = IDLE
  - `data` = 0, `dataChange` = 0
  - `busy` = 0, `frame_done` = 0
  - `in_ready` = 1
  - `prev_vld` = 0, `decim_q` = 0, decimation counter = 0
- Because `data`/`dataChange` reset to 0, downstream slot 0 is overwritten with 0 during reset. This is accepted behaviour.
- **Latency:** a sample kept in cycle n appears on `data`/`dataChange` in cycle n+1. Both outputs update in the same edge.
- **Frame end:** if the sample for slot 63 is kept in cycle n:
  - state = DONE and `frame_done` = 1 in cycle n+1, while `dataChange` = 63 is on the outputs.
  - IDLE in cycle n+2.
- **Minimum frame length:** with `decim_q = 0`, valid held high and a trigger at cycle t, slot 63 is presented at cycle t+64.
- `busy` is a registered decode of the state: it rises the cycle after `arm` is accepted and falls in DONE.
- **Reset mid-frame:** the block returns to IDLE immediately and the partial frame is abandoned. No `frame_done` is issued.
- **Stalls:** when `in_valid` is low, nothing advances. Counters, `prev` and the outputs hold.

## Structure
- Shared package `sew_pkg` holds:
  - `DATA_W`, `ADDR_W`, `DEPTH`
  - the `seq_state_t` enum {IDLE, ARMED, CAPTURE, DONE}
- `data_organize` and this block use the same package constants.
- One sub-module, `level_trigger`:
  - Contains `prev`, `prev_vld` and the crossing compare.
  - Inputs: `clk`, `rst`, `clear`, `sample_en`, `sample`, `threshold`.
  - Output: combinational `fire`.
- Everything else lives in the top module: FSM, decimation counter, output registers.

## Test plan
- **Reset:** assert `rst` mid-CAPTURE → next cycle state IDLE, `data` = 0, `dataChange` = 0, `busy` = 0, and no `frame_done` ever follows.
- **Basic frame:** `threshold` = 500, `decim` = 0, arm, then stream 100, 200, 600, 601, … → 600 is presented at slot 0. The 64 consecutive samples fill slots 0..63. `frame_done` is one cycle wide, in the cycle after slot 63 is kept.
- **Trigger edges:**
  - First sample after arm = 700 → no trigger.
  - Stream 500, 500 → no trigger.
  - Stream 499, 500 → triggers, and slot 0 = 500.
- **Decimation:** `decim` = 2 with a ramp 0, 1, 2, … after a trigger at value T → slot k = T + 3k. Changing `decim` to 0 mid-frame has no effect.
- **Backpressure and stall:**
  - Random gaps in `in_valid` → same slot contents as the gap-free run.
  - `in_ready` = 0 only in the DONE cycle, and a sample offered then is not consumed.
- **Arm handling:**
  - `arm` pulsed during CAPTURE and during DONE → ignored, and the block stays in IDLE after the frame.
  - A re-arm in IDLE restarts at slot 0.

Source files
------------

// File: rtl/sew_pkg.sv
// Shared constants and state encoding for the sample sequencer and data_organize.
package sew_pkg;

  localparam int DATA_W  = 11;
  localparam int ADDR_W  = 6;
  localparam int DEPTH   = 64;
  localparam int DECIM_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/level_trigger.sv
// Rising threshold-crossing detector: remembers the previous accepted sample
// and flags when the live sample crosses the threshold from below.
module level_trigger
  import sew_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] threshold,
  output logic              fire
);

  logic [DATA_W-1:0] prev;
  logic              prev_vld;

  // Previous-sample register; clear forgets history so the first sample after arming cannot fire.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
    if (rst || clear) begin
      prev     <= '0;
      prev_vld <= 1'b0;
    end else if (sample_en) begin
      prev     <= sample;
      prev_vld <= 1'b1;
    end
  end

  // Unsigned crossing compare against the live threshold.
  always_comb begin
    fire = prev_vld && (prev < threshold) && (sample >= threshold);
  end

endmodule

// File: rtl/sample_sequencer.sv
// Arms on request, waits for a rising threshold crossing, then emits DEPTH
// decimated samples as a registered (data, dataChange) slot-write pair.
module sample_sequencer
  import sew_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  input  logic               arm,
  input  logic [DATA_W-1:0]  threshold,
  input  logic [DECIM_W-1:0] decim,
  output logic [DATA_W-1:0]  data,
  output logic [ADDR_W-1:0]  dataChange,
  output logic               busy,
  output logic               frame_done
);

  seq_state_t         state;
  seq_state_t         state_next;
  logic [DECIM_W-1:0] decim_q;
  logic [DECIM_W-1:0] decim_cnt;
  logic               accept;
  logic               fire;
  logic               trigger;
  logic               keep;

  assign accept  = in_valid && in_ready;
  assign trigger = (state == ARMED) && accept && fire;
  assign keep    = (state == CAPTURE) && accept && (decim_cnt == decim_q);

  level_trigger u_level_trigger (
    .clk       (clk),
    .rst       (rst),
    .clear     (state == IDLE),
    .sample_en ((state == ARMED) && accept),
    .sample    (in_data),
    .threshold (threshold),
    .fire      (fire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state decode; the last kept slot ends the frame through DONE.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
    state_next = state;
    unique case (state)
      IDLE:    if (arm) state_next = ARMED;
      ARMED:   if (trigger) state_next = CAPTURE;
      CAPTURE: if (keep && (dataChange == ADDR_W'(DEPTH - 2))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are decodes of the registered state, so they change on clock edges only.
  always_comb begin
    in_ready   = (state != DONE);
    busy       = (state == ARMED) || (state == CAPTURE);
    frame_done = (state == DONE);
  end

  // Output pair and decimation control; data and dataChange always update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      data       <= '0;
      dataChange <= '0;
      decim_q    <= '0;
      decim_cnt  <= '0;
    end else if (trigger) begin
      data       <= in_data;
      dataChange <= '0;
      decim_q    <= decim;
      decim_cnt  <= '0;
    end else if ((state == CAPTURE) && accept) begin
      if (keep) begin
        data       <= in_data;
        dataChange <= dataChange + 1'b1;
        decim_cnt  <= '0;
      end else begin
        decim_cnt  <= decim_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed bench for sample_sequencer with a downstream slot-memory model.
module tb_sample_sequencer;
  import sew_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [DATA_W-1:0]  in_data;
  logic               in_ready;
  logic               arm;
  logic [DATA_W-1:0]  threshold;
  logic [DECIM_W-1:0] decim;
  logic [DATA_W-1:0]  data;
  logic [ADDR_W-1:0]  dataChange;
  logic               busy;
  logic               frame_done;

  int checks = 0;
  int passed = 0;

  logic [DATA_W-1:0] slot_mem [DEPTH];

  sample_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .arm        (arm),
    .threshold  (threshold),
    .decim      (decim),
    .data       (data),
    .dataChange (dataChange),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Downstream behaviour: every clock writes data into slot dataChange.
  always @(posedge clk) slot_mem[dataChange] <= data;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int value);
    in_valid = 1'b1;
    in_data  = DATA_W'(value);
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    cycle();
    arm = 1'b0;
  endtask

  // Streams a ramp starting at first until frame_done shows up or the budget runs out.
  task automatic stream(input int first, input bit gaps, input int decim_change_at,
                        input int arm_at, output int ncyc, output bit ok);
    int v;
    v    = first;
    ncyc = 0;
    ok   = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = '1;
      end else begin
        in_valid = 1'b1;
        in_data  = DATA_W'(v);
      end
      arm = (i == arm_at);
      if (i == decim_change_at) decim = '0;
      cycle();
      if (in_valid) v++;
      ncyc++;
      in_valid = 1'b0;
      arm      = 1'b0;
      if (frame_done) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    cycle();
    cycle();
    checks++;
    if (data !== '0 || dataChange !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_state: data=%0d slot=%0d busy=%b done=%b ready=%b, expected 0 0 0 0 1",
               data, dataChange, busy, frame_done, in_ready);
    else passed++;
    rst = 1'b0;
    threshold = 11'd500;
    decim     = '0;
    pulse_arm();
    send(100);
    send(600);
    send(601);
    send(602);
    checks++;
    if (data !== 11'd602 || dataChange !== 6'd2 || busy !== 1'b1)
      $display("FAIL pre_reset_capture: data=%0d slot=%0d busy=%b, expected 602 2 1", data, dataChange, busy);
    else passed++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++;
    if (data !== '0 || dataChange !== '0 || busy !== 1'b0 || frame_done !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL mid_frame_reset: data=%0d slot=%0d busy=%b done=%b ready=%b, expected 0 0 0 0 1",
               data, dataChange, busy, frame_done, in_ready);
    else passed++;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(i * 7);
      cycle();
      if (frame_done || busy) seen = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (seen !== 1'b0)
      $display("FAIL no_done_after_reset: activity seen=%b, expected 0", seen);
    else passed++;
  endtask

  task automatic test_basic_frame();
    int ncyc;
    bit ok;
    int errs;
    threshold = 11'd500;
    decim     = '0;
    pulse_arm();
    checks++;
    if (busy !== 1'b1) $display("FAIL busy_after_arm: busy=%b, expected 1", busy);
    else passed++;
    send(100);
    send(200);
    send(600);
    checks++;
    if (data !== 11'd600 || dataChange !== 6'd0)
      $display("FAIL basic_slot0: data=%0d slot=%0d, expected 600 0", data, dataChange);
    else passed++;
    stream(601, 1'b0, -1, -1, ncyc, ok);
    checks++;
    if (!ok || ncyc !== 63)
      $display("FAIL basic_frame_len: done=%b cycles=%0d, expected 1 63", ok, ncyc);
    else passed++;
    checks++;
    if (data !== 11'd663 || dataChange !== 6'd63 || in_ready !== 1'b0 || busy !== 1'b0)
      $display("FAIL done_cycle: data=%0d slot=%0d ready=%b busy=%b, expected 663 63 0 0",
               data, dataChange, in_ready, busy);
    else passed++;
    // A sample offered during DONE must not be consumed.
    in_valid = 1'b1;
    in_data  = 11'd999;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (frame_done !== 1'b0 || in_ready !== 1'b1 || data !== 11'd663 || dataChange !== 6'd63)
      $display("FAIL after_done: done=%b ready=%b data=%0d slot=%0d, expected 0 1 663 63",
               frame_done, in_ready, data, dataChange);
    else passed++;
    errs = 0;
    for (int k = 0; k < DEPTH; k++) if (slot_mem[k] !== DATA_W'(600 + k)) errs++;
    checks++;
    if (errs !== 0) $display("FAIL basic_slots: bad slots=%0d, expected 0", errs);
    else passed++;
  endtask

  task automatic test_trigger_edges();
    int ncyc;
    bit ok;
    int errs;
    threshold = 11'd500;
    decim     = '0;
    pulse_arm();
    send(700);
    checks++;
    if (data !== 11'd663 || dataChange !== 6'd63 || busy !== 1'b1)
      $display("FAIL first_sample_no_trig: data=%0d slot=%0d busy=%b, expected 663 63 1", data, dataChange, busy);
    else passed++;
    send(500);
    send(500);
    checks++;
    if (data !== 11'd663 || dataChange !== 6'd63)
      $display("FAIL equal_no_trig: data=%0d slot=%0d, expected 663 63", data, dataChange);
    else passed++;
    send(499);
    send(500);
    checks++;
    if (data !== 11'd500 || dataChange !== 6'd0)
      $display("FAIL cross_trig: data=%0d slot=%0d, expected 500 0", data, dataChange);
    else passed++;
    in_data = 11'd1234;
    cycle();
    cycle();
    cycle();
    checks++;
    if (data !== 11'd500 || dataChange !== 6'd0 || busy !== 1'b1)
      $display("FAIL stall_hold: data=%0d slot=%0d busy=%b, expected 500 0 1", data, dataChange, busy);
    else passed++;
    stream(501, 1'b1, -1, -1, ncyc, ok);
    checks++;
    if (!ok || dataChange !== 6'd63 || data !== 11'd563)
      $display("FAIL gap_frame_end: done=%b data=%0d slot=%0d, expected 1 563 63", ok, data, dataChange);
    else passed++;
    cycle();
    errs = 0;
    for (int k = 0; k < DEPTH; k++) if (slot_mem[k] !== DATA_W'(500 + k)) errs++;
    checks++;
    if (errs !== 0) $display("FAIL gap_slots: bad slots=%0d, expected 0", errs);
    else passed++;
  endtask

  task automatic test_decim_and_arm();
    int ncyc;
    bit ok;
    int errs;
    threshold = 11'd100;
    decim     = 8'd2;
    pulse_arm();
    send(50);
    send(100);
    checks++;
    if (data !== 11'd100 || dataChange !== 6'd0)
      $display("FAIL decim_slot0: data=%0d slot=%0d, expected 100 0", data, dataChange);
    else passed++;
    // decim drops to 0 and arm pulses mid-frame; neither may disturb the frame.
    stream(101, 1'b0, 5, 20, ncyc, ok);
    checks++;
    if (!ok || ncyc !== 189 || data !== 11'd289 || dataChange !== 6'd63)
      $display("FAIL decim_frame_end: done=%b cycles=%0d data=%0d slot=%0d, expected 1 189 289 63",
               ok, ncyc, data, dataChange);
    else passed++;
    arm = 1'b1;
    cycle();
    arm = 1'b0;
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL arm_in_done: busy=%b done=%b, expected 0 0", busy, frame_done);
    else passed++;
    cycle();
    checks++;
    if (busy !== 1'b0) $display("FAIL stays_idle: busy=%b, expected 0", busy);
    else passed++;
    errs = 0;
    for (int k = 0; k < DEPTH; k++) if (slot_mem[k] !== DATA_W'(100 + 3 * k)) errs++;
    checks++;
    if (errs !== 0) $display("FAIL decim_slots: bad slots=%0d, expected 0", errs);
    else passed++;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    arm       = 1'b0;
    threshold = '0;
    decim     = '0;
    test_reset();
    test_basic_frame();
    test_trigger_edges();
    test_decim_and_arm();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
